// File: rtl/box_pkg.sv
// Shared encodings and widths for the register-box command path.
// Pairs with the 4-entry, 8-bit register box.
package box_pkg;

  localparam int BOX_DATA_W = 8;
  localparam int BOX_ADDR_W = 2;

  typedef enum logic [1:0] {
    OP_NOP = 2'b00,
    OP_WR  = 2'b01,
    OP_RD  = 2'b10,
    OP_VFY = 2'b11
  } cmd_op_e;

  typedef enum logic [1:0] {
    ST_OK       = 2'b00,
    ST_WR_ACK   = 2'b01,
    ST_TIMEOUT  = 2'b10,
    ST_MISMATCH = 2'b11
  } rsp_status_e;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ISSUE_WR = 3'd1,
    S_ISSUE_RD = 3'd2,
    S_WAIT     = 3'd3,
    S_RESP     = 3'd4
  } state_e;

endpackage

// File: rtl/box_cmd_ctrl.sv
// Single-outstanding command sequencer in front of the register box:
// issues write/read pulses, waits for read_active, returns one response per command.
module box_cmd_ctrl
  import box_pkg::*;
#(
  parameter int DATA_W  = BOX_DATA_W,
  parameter int ADDR_W  = BOX_ADDR_W,
  parameter int TIMEOUT = 4,
  parameter int ERR_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [1:0]        rsp_status,
  output logic              box_read_enable,
  output logic              box_write_enable,
  output logic [ADDR_W-1:0] box_address,
  output logic [DATA_W-1:0] box_write_data,
  input  logic [DATA_W-1:0] box_read_data,
  input  logic              box_read_active,
  output logic [ERR_W-1:0]  err_count
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_e            state_q, state_d;
  cmd_op_e           op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  rsp_status_e       rsp_status_q, rsp_status_d;
  logic [ERR_W-1:0]  err_q, err_d;
  logic              err_bump;

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    addr_d       = addr_q;
    data_d       = data_q;
    cnt_d        = cnt_q;
    rsp_data_d   = rsp_data_q;
    rsp_status_d = rsp_status_q;
    err_bump     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          op_d   = cmd_op_e'(cmd_op);
          addr_d = cmd_addr;
          data_d = cmd_data;
          case (cmd_op_e'(cmd_op))
            OP_NOP: begin
              state_d      = S_RESP;
              rsp_data_d   = '0;
              rsp_status_d = ST_OK;
            end
            OP_RD:   state_d = S_ISSUE_RD;
            default: state_d = S_ISSUE_WR;
          endcase
        end
      end
      S_ISSUE_WR: begin
        if (op_q == OP_VFY) begin
          state_d = S_ISSUE_RD;
        end else begin
          state_d      = S_RESP;
          rsp_data_d   = data_q;
          rsp_status_d = ST_WR_ACK;
        end
      end
      S_ISSUE_RD: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // A late read_active still beats the timeout in the same cycle.
        if (box_read_active) begin
          state_d    = S_RESP;
          rsp_data_d = box_read_data;
          if (op_q == OP_VFY && box_read_data != data_q) begin
            rsp_status_d = ST_MISMATCH;
            err_bump     = 1'b1;
          end else begin
            rsp_status_d = ST_OK;
          end
        end else if (cnt_q == CNT_LAST) begin
          state_d      = S_RESP;
          rsp_data_d   = '0;
          rsp_status_d = ST_TIMEOUT;
          err_bump     = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    err_d = err_q;
    if (err_bump && err_q != '1) err_d = err_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      op_q         <= OP_NOP;
      addr_q       <= '0;
      data_q       <= '0;
      cnt_q        <= '0;
      rsp_data_q   <= '0;
      rsp_status_q <= ST_OK;
      err_q        <= '0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      cnt_q        <= cnt_d;
      rsp_data_q   <= rsp_data_d;
      rsp_status_q <= rsp_status_d;
      err_q        <= err_d;
    end
  end

  // Everything below decodes from registered state, so the box pins never glitch.
  assign cmd_ready        = (state_q == S_IDLE);
  assign rsp_valid        = (state_q == S_RESP);
  assign rsp_data         = rsp_data_q;
  assign rsp_status       = rsp_status_q;
  assign box_write_enable = (state_q == S_ISSUE_WR);
  assign box_read_enable  = (state_q == S_ISSUE_RD);
  assign box_address      = (state_q == S_IDLE) ? '0 : addr_q;
  assign box_write_data   = (state_q == S_IDLE) ? '0 : data_q;
  assign err_count        = err_q;

endmodule

// File: tb/tb_box_cmd_ctrl.sv
// Randomized bench for box_cmd_ctrl with a behavioural register-box model attached
// and a command-level reference model predicting response, latency and error count.
module tb_box_cmd_ctrl;

  localparam int TIMEOUT = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [1:0] cmd_addr;
  logic [7:0] cmd_data;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic [1:0] rsp_status;
  logic       box_read_enable;
  logic       box_write_enable;
  logic [1:0] box_address;
  logic [7:0] box_write_data;
  logic [7:0] box_read_data;
  logic       box_read_active;
  logic [7:0] err_count;

  int vectors = 0;
  int miscompares = 0;

  box_cmd_ctrl #(
    .DATA_W (8),
    .ADDR_W (2),
    .TIMEOUT(TIMEOUT),
    .ERR_W  (8)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_op          (cmd_op),
    .cmd_addr        (cmd_addr),
    .cmd_data        (cmd_data),
    .rsp_valid       (rsp_valid),
    .rsp_ready       (rsp_ready),
    .rsp_data        (rsp_data),
    .rsp_status      (rsp_status),
    .box_read_enable (box_read_enable),
    .box_write_enable(box_write_enable),
    .box_address     (box_address),
    .box_write_data  (box_write_data),
    .box_read_data   (box_read_data),
    .box_read_active (box_read_active),
    .err_count       (err_count)
  );

  always #5 clk = ~clk;

  // Register box model: write and read land on the edge after the enable pulse,
  // read_active follows read_enable by one cycle unless the test suppresses it.
  logic [7:0] box_mem [4];
  logic       box_active_r;
  logic [7:0] box_rdata_r;
  bit         force_inactive = 1'b0;
  bit         force_data_en = 1'b0;
  logic [7:0] force_val = 8'h00;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) box_mem[i] <= 8'h00;
      box_active_r <= 1'b0;
      box_rdata_r  <= 8'h00;
    end else begin
      if (box_write_enable) box_mem[box_address] <= box_write_data;
      box_active_r <= box_read_enable && !force_inactive;
      if (box_read_enable) box_rdata_r <= box_mem[box_address];
    end
  end

  assign box_read_active = box_active_r;
  assign box_read_data   = force_data_en ? force_val : box_rdata_r;

  // Pulse monitor on the box pins.
  int         we_pulses = 0;
  int         re_pulses = 0;
  int         overlaps = 0;
  logic [1:0] we_addr = 2'd0;
  logic [1:0] re_addr = 2'd0;
  logic [7:0] we_wdata = 8'h00;

  always @(negedge clk) begin
    if (box_write_enable) begin
      we_pulses <= we_pulses + 1;
      we_addr   <= box_address;
      we_wdata  <= box_write_data;
    end
    if (box_read_enable) begin
      re_pulses <= re_pulses + 1;
      re_addr   <= box_address;
    end
    if (box_write_enable && box_read_enable) overlaps <= overlaps + 1;
  end

  // Command-level reference state.
  logic [7:0] ref_mem [4];
  logic [7:0] ref_err;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic refModel(input logic [1:0] op, input logic [1:0] addr, input logic [7:0] data,
                          output logic [7:0] exp_data, output logic [1:0] exp_status,
                          output int exp_lat, output int exp_we, output int exp_re);
    logic [7:0] rd;
    logic       bad;
    bad = 1'b0;
    case (op)
      2'b00: begin
        exp_data = 8'h00; exp_status = 2'b00; exp_lat = 1; exp_we = 0; exp_re = 0;
      end
      2'b01: begin
        ref_mem[addr] = data;
        exp_data = data; exp_status = 2'b01; exp_lat = 2; exp_we = 1; exp_re = 0;
      end
      2'b10: begin
        exp_we = 0; exp_re = 1;
        if (force_inactive) begin
          exp_data = 8'h00; exp_status = 2'b10; exp_lat = 2 + TIMEOUT; bad = 1'b1;
        end else begin
          exp_data = force_data_en ? force_val : ref_mem[addr];
          exp_status = 2'b00; exp_lat = 3;
        end
      end
      default: begin
        ref_mem[addr] = data;
        exp_we = 1; exp_re = 1;
        if (force_inactive) begin
          exp_data = 8'h00; exp_status = 2'b10; exp_lat = 3 + TIMEOUT; bad = 1'b1;
        end else begin
          rd = force_data_en ? force_val : data;
          exp_data = rd; exp_lat = 4;
          exp_status = (rd == data) ? 2'b00 : 2'b11;
          bad = (rd != data);
        end
      end
    endcase
    if (bad && ref_err != 8'hFF) ref_err = ref_err + 8'd1;
  endtask

  task automatic applyStimulus(input logic [1:0] op, input logic [1:0] addr,
                               input logic [7:0] data, input int hold);
    logic [7:0] exp_data;
    logic [1:0] exp_status;
    int         exp_lat, exp_we, exp_re;
    int         we0, re0, lat;
    bit         seen;

    refModel(op, addr, data, exp_data, exp_status, exp_lat, exp_we, exp_re);

    @(negedge clk);
    checkOutput("cmd_ready_idle", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = addr;
    cmd_data  = data;
    rsp_ready = (hold == 0);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    we0 = we_pulses;
    re0 = re_pulses;

    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 64) begin
      @(negedge clk);
      lat++;
      if (rsp_valid) seen = 1'b1;
    end
    checkOutput("rsp_arrived", 32'(seen), 32'd1);
    checkOutput("latency", 32'(lat), 32'(exp_lat));
    checkOutput("rsp_data", 32'(rsp_data), 32'(exp_data));
    checkOutput("rsp_status", 32'(rsp_status), 32'(exp_status));
    checkOutput("err_count", 32'(err_count), 32'(ref_err));

    // Backpressure: the response must hold still and new commands must be refused.
    for (int i = 0; i < hold; i++) begin
      cmd_valid = 1'b1;
      cmd_op    = 2'($urandom_range(1, 3));
      cmd_addr  = 2'($urandom);
      cmd_data  = 8'($urandom);
      @(negedge clk);
      checkOutput("hold_valid", 32'(rsp_valid), 32'd1);
      checkOutput("hold_data", 32'(rsp_data), 32'(exp_data));
      checkOutput("hold_status", 32'(rsp_status), 32'(exp_status));
      checkOutput("hold_cmd_ready", 32'(cmd_ready), 32'd0);
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("post_hs_valid", 32'(rsp_valid), 32'd0);
    checkOutput("post_hs_ready", 32'(cmd_ready), 32'd1);
    checkOutput("we_pulses", 32'(we_pulses - we0), 32'(exp_we));
    checkOutput("re_pulses", 32'(re_pulses - re0), 32'(exp_re));
    if (exp_we != 0) begin
      checkOutput("we_addr", 32'(we_addr), 32'(addr));
      checkOutput("we_wdata", 32'(we_wdata), 32'(data));
    end
    if (exp_re != 0) checkOutput("re_addr", 32'(re_addr), 32'(addr));
  endtask

  initial begin
    for (int i = 0; i < 4; i++) ref_mem[i] = 8'h00;
    ref_err   = 8'h00;
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_addr  = 2'd0;
    cmd_data  = 8'h00;
    rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("rst_rsp_data", 32'(rsp_data), 32'd0);
    checkOutput("rst_rsp_status", 32'(rsp_status), 32'd0);
    checkOutput("rst_err_count", 32'(err_count), 32'd0);
    checkOutput("rst_enables", 32'({box_write_enable, box_read_enable}), 32'd0);
    checkOutput("rst_address", 32'(box_address), 32'd0);
    rst = 1'b0;

    $display("[TB] directed sequence");
    applyStimulus(2'b01, 2'd2, 8'hA5, 0);
    applyStimulus(2'b10, 2'd2, 8'h00, 0);
    applyStimulus(2'b11, 2'd1, 8'h3C, 0);
    force_inactive = 1'b1;
    applyStimulus(2'b10, 2'd0, 8'h00, 0);
    force_inactive = 1'b0;
    force_data_en = 1'b1;
    force_val     = 8'hAA;
    applyStimulus(2'b11, 2'd3, 8'h55, 0);
    force_data_en = 1'b0;
    applyStimulus(2'b10, 2'd1, 8'h00, 5);

    $display("[TB] reset during WAIT");
    force_inactive = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = 2'b10;
    cmd_addr  = 2'd2;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("pre_rst_waiting", 32'(rsp_valid), 32'd0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("mid_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    checkOutput("mid_rst_enables", 32'({box_write_enable, box_read_enable}), 32'd0);
    checkOutput("mid_rst_err_count", 32'(err_count), 32'd0);
    rst = 1'b0;
    force_inactive = 1'b0;
    ref_err = 8'h00;
    for (int i = 0; i < 4; i++) ref_mem[i] = 8'h00;
    applyStimulus(2'b00, 2'd0, 8'h00, 0);

    $display("[TB] random sequence");
    for (int n = 0; n < 150; n++) begin
      int r;
      r = int'($urandom_range(0, 9));
      force_inactive = (r == 0);
      force_data_en  = (r == 1);
      force_val      = 8'($urandom);
      applyStimulus(2'($urandom), 2'($urandom), 8'($urandom),
                    ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0);
    end
    force_inactive = 1'b0;
    force_data_en  = 1'b0;

    checkOutput("enable_overlap", 32'(overlaps), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/box_cmd_ctrl.md
Name: box_cmd_ctrl

Overview:
- Command sequencer that sits directly upstream of the 4-entry register box.
- Accepts one command at a time on a valid/ready stream and drives the box's read_enable, write_enable, address and write_data pins.
- Captures read_data when the box reports read_active, and returns exactly one response per command on a valid/ready response stream.
- Adds write-then-verify, a read timeout and a saturating error counter.

Parameters:
- DATA_W, 8, data width; matches the box register width.
- ADDR_W, 2, address width; matches the box depth of 4.
- TIMEOUT, 4, WAIT cycles allowed for read_active before a timeout response; must be >= 1.
- ERR_W, 8, width of err_count.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready at a clk edge
- cmd_op  in  2  00 NOP, 01 WRITE, 10 READ, 11 VERIFY (write then read back)
- cmd_addr  in  ADDR_W  target register
- cmd_data  in  DATA_W  write data (WRITE/VERIFY)
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready
- rsp_data  out  DATA_W  read or echoed data
- rsp_status  out  2  00 OK, 01 WR_ACK, 10 TIMEOUT, 11 MISMATCH
- box_read_enable  out  1  to box read_enable
- box_write_enable  out  1  to box write_enable
- box_address  out  ADDR_W  to box address
- box_write_data  out  DATA_W  to box write_data
- box_read_data  in  DATA_W  from box read_data
- box_read_active  in  1  from box read_active
- err_count  out  ERR_W  saturating count of TIMEOUT + MISMATCH responses

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE; rsp_valid=0, rsp_data=0, rsp_status=00, err_count=0.
  - Latched op/addr/data=0, timeout counter=0.
  - Box enables are 0 during and after reset.
  - Reset mid-operation abandons the command with no response.
- FSM states: IDLE, ISSUE_WR, ISSUE_RD, WAIT, RESP.
- Only one command is outstanding at a time.
- cmd_ready=1 iff state==IDLE; it has no combinational dependency on cmd_valid.
- IDLE: on handshake, latch op/addr/data, then branch on op:
  - NOP -> RESP with data=0, status OK.
  - WRITE or VERIFY -> ISSUE_WR.
  - READ -> ISSUE_RD.
- box_address = latched addr in all states; 0 in IDLE.
- box_write_data = latched data in all states; 0 in IDLE.
- ISSUE_WR (exactly 1 cycle): box_write_enable=1.
  - WRITE -> RESP with data=latched data, status WR_ACK.
  - VERIFY -> ISSUE_RD.
- ISSUE_RD (exactly 1 cycle): box_read_enable=1; counter cleared; -> WAIT.
- The box applies the write and read on separate edges, so VERIFY reads the new value.
- WAIT:
  - If box_read_active=1: capture box_read_data into rsp_data and go to RESP.
    - READ: status OK.
    - VERIFY: status OK if the captured data equals the latched data, else MISMATCH.
  - Else the counter increments; when it reaches TIMEOUT-1 without active: rsp_data=0, status TIMEOUT, -> RESP.
  - read_active in the same cycle as the timeout condition wins (OK/MISMATCH).
- RESP: rsp_valid=1 with rsp_data/rsp_status held stable until rsp_ready; on handshake -> IDLE, rsp_valid=0 next cycle.
- Next command is accepted no earlier than the cycle after the response handshake.
- Latency from command-accept edge to first rsp_valid cycle, with no backpressure:
  - NOP 1 cycle
  - WRITE 2 cycles
  - READ 3 cycles
  - VERIFY 4 cycles
- Box enables are never both 1 in the same cycle. Each enable is a single-cycle pulse per command.
- err_count increments on entry to RESP with status TIMEOUT or MISMATCH; it saturates at all-ones.
- Address values wrap naturally within ADDR_W; there is no range check.

Decomposition:
- Shared package box_pkg holds:
  - cmd_op encodings: OP_NOP, OP_WR, OP_RD, OP_VFY
  - rsp_status encodings: ST_OK, ST_WR_ACK, ST_TIMEOUT, ST_MISMATCH
  - FSM state enum
  - BOX_DATA_W=8, BOX_ADDR_W=2
- No sub-module. The timeout counter and saturating err counter stay inline; the FSM is a single always block plus output decode.

Test Plan:
- WRITE addr 2 data 0xA5, rsp_ready=1 -> box_write_enable pulses one cycle with address 2; rsp_valid 2 cycles after accept, data 0xA5, status WR_ACK; then READ addr 2 -> data 0xA5, status OK, rsp_valid 3 cycles after accept.
- VERIFY addr 1 data 0x3C with real box attached -> write pulse then read pulse on consecutive cycles; response data 0x3C, status OK, err_count stays 0.
- READ with box_read_active forced 0, TIMEOUT=4 -> response after 4 WAIT cycles: data 0x00, status TIMEOUT, err_count 1.
- VERIFY addr 3 data 0x55 with box_read_data forced 0xAA -> status MISMATCH, data 0xAA, err_count increments.
- rsp_ready held 0 for 5 cycles during a READ response -> rsp_valid/data/status stable; cmd_ready=0 throughout; a new cmd_valid is ignored until after the handshake.
- rst asserted in the WAIT state -> next cycle rsp_valid=0, cmd_ready=1, box enables 0, err_count 0; NOP afterwards -> response data 0x00, status OK, 1 cycle after accept.
